dual_index_decoder: RTL
=======================

DUAL_INDEX_DECODER -- requirements
Module: dual_index_decoder

Interface
REQ-001 Parameter INPUT_BITS, default 12: width of the grant/mask vectors; index width is 4 bits.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  an index pair is offered.
REQ-005 in_ready  output  1  the block accepts a pair this cycle.
REQ-006 first  input  4  highest-priority index.
REQ-007 first_vld  input  1  first is meaningful.
REQ-008 second  input  4  next-priority index.
REQ-009 second_vld  input  1  second is meaningful.
REQ-010 grant  output  INPUT_BITS  one-hot grant for the index currently presented.
REQ-011 out_valid  output  1  grant is valid.
REQ-012 out_ready  input  1  the consumer accepts grant.
REQ-013 out_last  output  1  the current grant is the final one of the pair.
REQ-014 mask  output  INPUT_BITS  accumulated OR of all grants issued for the most recent pair.
REQ-015 done  output  1  one-cycle pulse marking that the pair is finished.
REQ-016 err  output  1  one-cycle pulse marking an out-of-range index.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EMIT_FIRST and EMIT_SECOND.
REQ-018 in_ready SHALL equal (state==IDLE).
REQ-019 A capture occurs on a rising edge where in_valid and in_ready are both 1.
REQ-020 An index is usable when its vld bit is 1 and its value is less than INPUT_BITS.
REQ-021 second is usable only if it is also not equal to first.
REQ-022 On capture, if first is usable, the next state SHALL be EMIT_FIRST.
REQ-023 On capture, if first is unusable and second is usable, the next state SHALL be EMIT_SECOND.
REQ-024 On capture, if neither index is usable, the FSM SHALL stay in IDLE and pulse done in the following cycle with mask = 0.
REQ-025 On capture, mask SHALL clear to 0.
REQ-026 A vld=1 index with value >= INPUT_BITS SHALL pulse err for one cycle (the cycle after capture) and SHALL be discarded.
REQ-027 Duplicates (first == second) SHALL NOT raise err.
REQ-028 In EMIT_FIRST and EMIT_SECOND, out_valid = 1 and grant = 1 << (current index); otherwise out_valid = 0 and grant = 0.
REQ-029 out_last SHALL be 1 in EMIT_SECOND.
REQ-030 out_last SHALL be 1 in EMIT_FIRST when second is unusable, and 0 otherwise.
REQ-031 While out_valid=1 and out_ready=0, grant, out_last and state SHALL hold stable.
REQ-032 On an output handshake, mask SHALL be ORed with grant.
REQ-033 On an output handshake in EMIT_FIRST, the next state SHALL be EMIT_SECOND if second is usable, else IDLE.
REQ-034 On an output handshake in EMIT_SECOND, the next state SHALL be IDLE.
REQ-035 On the handshake where out_last=1, done SHALL pulse in the next cycle, coincident with IDLE.
REQ-036 mask SHALL hold its value until the next capture.
REQ-037 Latency: capture at edge N gives out_valid=1 in cycle N+1; with out_ready held at 1, a two-index pair completes in 2 cycles and done is at N+3.
REQ-038 The input and output handshakes cannot occur in the same cycle (in_ready=0 while out_valid=1); back-to-back pairs have a 1-cycle IDLE gap minimum.
REQ-039 first, second and the vld bits SHALL be sampled only at capture; later changes have no effect.

Reset
REQ-040 While reset=1: state=IDLE, grant=0, out_valid=0, out_last=0, mask=0, done=0, err=0, and stored indices are cleared.
REQ-041 in_ready SHALL read 1 during reset, but no capture SHALL occur while reset=1.
REQ-042 Reset asserted mid-pair SHALL abort the pair with no done pulse.
REQ-043 After reset deasserts, the first capture is possible on the next rising edge.

Verification
REQ-044 first=9/vld, second=3/vld, out_ready=1: grant 0x200 (out_last=0), then 0x008 (out_last=1); done pulse; mask=0x208.
REQ-045 first=5/vld, second_vld=0: a single grant 0x020 with out_last=1; done; mask=0x020.
REQ-046 first=7, second=7, both vld: a single grant 0x080, out_last=1, no err; mask=0x080.
REQ-047 first=14/vld, second=2/vld: err pulse one cycle after capture; a single grant 0x004 (EMIT_SECOND); mask=0x004.
REQ-048 Pair 11/0 with out_ready low for 3 cycles: grant holds 0x800 for 4 cycles, then 0x001; in_ready=0 throughout; done follows.
REQ-049 reset pulsed while grant=0x001 is stalled: outputs go to 0 immediately; no done pulse; the next pair 4/- gives grant 0x010.

Source files
------------

// File: rtl/dual_index_decoder.sv
// Turns a prioritised pair of 4-bit indices into up to two one-hot grants,
// issued in order under a valid/ready handshake, and accumulates a grant mask.
module dual_index_decoder #(
    parameter int INPUT_BITS = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            first,
    input  logic                  first_vld,
    input  logic [3:0]            second,
    input  logic                  second_vld,
    output logic [INPUT_BITS-1:0] grant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [INPUT_BITS-1:0] mask,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        EMIT_FIRST  = 2'd1,
        EMIT_SECOND = 2'd2
    } state_t;

    localparam logic [4:0]            LIMIT    = 5'(INPUT_BITS);
    localparam logic [INPUT_BITS-1:0] ONE_HOT0 = {{(INPUT_BITS-1){1'b0}}, 1'b1};
    localparam logic [INPUT_BITS-1:0] ZERO_VEC = {INPUT_BITS{1'b0}};

    state_t                  state_q, state_d;
    logic [3:0]              second_idx_q, second_idx_d;
    logic                    second_ok_q, second_ok_d;
    logic [INPUT_BITS-1:0]   grant_q, grant_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [INPUT_BITS-1:0]   mask_q, mask_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    capture_s;
    logic                    first_ok_s;
    logic                    second_ok_s;
    logic                    first_oor_s;
    logic                    second_oor_s;

    // Qualify the offered indices; a second that duplicates a usable first is dropped silently.
    always_comb begin
        capture_s    = in_valid && (state_q == IDLE);
        first_oor_s  = first_vld  && ({1'b0, first}  >= LIMIT);
        second_oor_s = second_vld && ({1'b0, second} >= LIMIT);
        first_ok_s   = first_vld && !first_oor_s;
        second_ok_s  = second_vld && !second_oor_s && !(first_ok_s && (second == first));
    end

    // Next-state and registered-output computation for the emit sequence.
    always_comb begin
        state_d      = state_q;
        second_idx_d = second_idx_q;
        second_ok_d  = second_ok_q;
        grant_d      = grant_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        mask_d       = mask_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_s) begin
                    mask_d       = ZERO_VEC;
                    err_d        = first_oor_s || second_oor_s;
                    second_idx_d = second;
                    second_ok_d  = second_ok_s;
                    if (first_ok_s) begin
                        state_d     = EMIT_FIRST;
                        grant_d     = ONE_HOT0 << first;
                        out_valid_d = 1'b1;
                        out_last_d  = !second_ok_s;
                    end else if (second_ok_s) begin
                        state_d     = EMIT_SECOND;
                        grant_d     = ONE_HOT0 << second;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                    end else begin
                        done_d      = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT_FIRST: begin
                if (out_ready) begin
                    mask_d = mask_q | grant_q;
                    if (second_ok_q) begin
                        state_d    = EMIT_SECOND;
                        grant_d    = ONE_HOT0 << second_idx_q;
                        out_last_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        grant_d     = ZERO_VEC;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end else begin
                    state_d = EMIT_FIRST;
                end
            end
            EMIT_SECOND: begin
                if (out_ready) begin
                    mask_d      = mask_q | grant_q;
                    state_d     = IDLE;
                    grant_d     = ZERO_VEC;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = EMIT_SECOND;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = ZERO_VEC;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any pair in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            second_idx_q <= 4'd0;
            second_ok_q  <= 1'b0;
            grant_q      <= ZERO_VEC;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            mask_q       <= ZERO_VEC;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            second_idx_q <= second_idx_d;
            second_ok_q  <= second_ok_d;
            grant_q      <= grant_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            mask_q       <= mask_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign mask      = mask_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
